// File: rtl/vend_if.sv
// Keypad/coin/price-table bundle for the vending sequencer.
// master drives the requests and table data; slave is the controller.
interface vend_if #(
   parameter int CW = 8
);
   logic          key_valid;
   logic [1:0]    key_code;
   logic          cancel;
   logic          coin_valid;
   logic [CW-1:0] coin_value;
   logic [CW-1:0] price;
   logic          stock_ok;
   logic          enL;
   logic          enC;
   logic [1:0]    code;
   logic          reg_clr;
   logic          dispense;
   logic          change_valid;
   logic [CW-1:0] change;
   logic [CW-1:0] credit;
   logic          coin_reject;
   logic          busy;

   modport master (
      output key_valid, key_code, cancel, coin_valid, coin_value,
      output price, stock_ok,
      input  enL, enC, code, reg_clr, dispense, change_valid,
      input  change, credit, coin_reject, busy
   );

   modport slave (
      input  key_valid, key_code, cancel, coin_valid, coin_value,
      input  price, stock_ok,
      output enL, enC, code, reg_clr, dispense, change_valid,
      output change, credit, coin_reject, busy
   );
endinterface

// File: rtl/vend_controller.sv
// Vending selection/payment sequencer: keypad, coin credit, vend, refund.
// Optional idle auto-cancel enabled by defining VEND_TIMEOUT_EN.
module vend_controller #(
   parameter int CW      = 8,
   parameter int TIMEOUT = 1000
) (
   input logic clk,
   input logic clr,
   vend_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, LOAD_ROW, WAIT_COL, LOAD_COL,
      CHECK, WAIT_PAY, VEND, REFUND
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] credit_q, credit_n;
   logic [CW-1:0] price_q, price_n;
   logic [1:0]    code_q, code_n;
   logic          reg_clr_q;
   logic          accept, cancel_go, timeout;
   logic [CW:0]   sum;
   logic [CW-1:0] coin_credit, remain;

   always_comb begin
      accept = (state == IDLE) || (state == WAIT_COL) ||
               (state == WAIT_PAY);
      sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
      coin_credit = credit_q;
      if (bus.coin_valid && accept)
         coin_credit = sum[CW] ? '1 : sum[CW-1:0];
      cancel_go = (bus.cancel || timeout) &&
                  (state != VEND) && (state != REFUND);
      remain   = credit_q - price_q;
      state_n  = state;
      credit_n = coin_credit;
      price_n  = price_q;
      code_n   = code_q;
      unique case (state)
         IDLE: if (bus.key_valid) begin
            code_n  = bus.key_code;
            state_n = LOAD_ROW;
         end
         LOAD_ROW: state_n = WAIT_COL;
         WAIT_COL: if (bus.key_valid) begin
            code_n  = bus.key_code;
            state_n = LOAD_COL;
         end
         LOAD_COL: state_n = CHECK;
         CHECK: begin
            // latched so VEND does not depend on the table still settling
            price_n = bus.price;
            if (!bus.stock_ok)
               state_n = REFUND;
            else if (credit_q < bus.price)
               state_n = WAIT_PAY;
            else
               state_n = VEND;
         end
         WAIT_PAY: if (bus.coin_valid) state_n = CHECK;
         VEND: begin
            credit_n = remain;
            state_n  = (remain != '0) ? REFUND : IDLE;
         end
         REFUND: begin
            credit_n = '0;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (cancel_go) begin
         code_n  = code_q;
         state_n = (coin_credit != '0) ? REFUND : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         credit_q  <= '0;
         price_q   <= '0;
         code_q    <= '0;
         reg_clr_q <= 1'b0;
      end else begin
         state     <= state_n;
         credit_q  <= credit_n;
         price_q   <= price_n;
         code_q    <= code_n;
         reg_clr_q <= (state != IDLE) && (state_n == IDLE);
      end
   end

`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          waiting;

   assign waiting = (state == WAIT_COL) || (state == WAIT_PAY);
   assign timeout = waiting && (tcnt == TW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (clr)
         tcnt <= '0;
      else if (!waiting || state_n != state ||
               bus.key_valid || bus.coin_valid)
         tcnt <= '0;
      else if (!timeout)
         tcnt <= tcnt + 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout = 1'b0;
`endif

   assign bus.enL          = (state == LOAD_ROW);
   assign bus.enC          = (state == LOAD_COL);
   assign bus.code         = code_q;
   assign bus.reg_clr      = reg_clr_q;
   assign bus.dispense     = (state == VEND);
   assign bus.change_valid = (state == REFUND);
   assign bus.change       = (state == REFUND) ? credit_q : '0;
   assign bus.credit       = credit_q;
   assign bus.coin_reject  = bus.coin_valid && !accept;
   assign bus.busy         = (state != IDLE);
endmodule
